stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Sequential counterpart of the 2:1 `mux` primitive: one valid/ready input stream is steered to one of N_OUT output channels, chosen by a per-beat select.
- Each output channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Used wherever one producer feeds several consumers, for example a dispatcher feeding parallel workers.

Parameters:
- N_OUT, 4, number of output channels (2..16; need not be a power of two).
- W, 8, data width in bits.
- SEL_W, $clog2(N_OUT) with a minimum of 1, width of the select field (localparam, derived).
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  an input beat is offered.
- in_ready  output  1  the offered beat is accepted this cycle.
- in_sel  input  SEL_W  destination channel of the beat.
- in_data  input  W  payload.
- out_valid  output  N_OUT  bit k: channel k holds a beat.
- out_ready  input  N_OUT  bit k: consumer k takes the beat.
- out_data  output  N_OUT*W  channel k occupies bits [k*W +: W].
- drop_cnt  output  CNT_W  number of beats dropped because their select was out of range; saturating.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the environment): out_valid=0, out_data=0, drop_cnt=0. Any beats held at the moment of reset are lost, including during mid-operation.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer on channel k occurs when out_valid[k] && out_ready[k].
- in_ready (combinational), with s = in_sel:
  - If s >= N_OUT: in_ready=1.
  - Otherwise: in_ready = !out_valid[s] || out_ready[s].
  - in_ready depends on in_sel and out_ready only; it never depends on in_valid. The out_ready-to-in_ready path is combinational and documented.
- Accepted beat with s < N_OUT:
  - At the clock edge, out_data[s] <= in_data and out_valid[s] <= 1.
  - Latency is 1 cycle: the beat is visible on the cycle after acceptance.
- Same-edge drain and refill of channel s: the new beat is loaded, out_valid[s] stays 1, and there is no bubble. Full throughput is 1 beat/cycle to a single channel whose consumer is always ready.
- Drain-only on channel k: out_valid[k] <= 0 and out_data[k] is held (not cleared).
- Stall: while out_valid[k] && !out_ready[k], out_data[k] is stable.
- Only the selected channel can be loaded in a given cycle. Other channels drain independently and concurrently.
- Out-of-range select (s >= N_OUT, accepted):
  - The beat is discarded and no out_valid changes.
  - drop_cnt increments by 1 and saturates at 2^CNT_W-1; it never wraps.
  - When N_OUT is a power of two this case is unreachable, and drop_cnt stays 0.
- in_sel and in_data are don't-care when in_valid=0. The block's state must not change in that case.
- No X propagation: out_data is reset to 0.

Decomposition:
- Package stream_demux_pkg holds:
  - default localparams DEMUX_N_OUT=4, DEMUX_W=8, DEMUX_CNT_W=8;
  - function sel_w(n), returning max(1, $clog2(n)).
- Sub-module demux_slot: a one-entry register with load/valid/ready/data. It is instantiated N_OUT times in a generate loop, with load = in_valid && in_ready && (in_sel == k).
- The top level holds the in_ready mux and the drop counter.

Test Plan:
- Reset: assert rst_n=0 mid-stream with channel 2 holding 0xA5 -> out_valid=0000, out_data=0, drop_cnt=0 immediately, before any clock edge.
- Basic steer: N_OUT=4; send 0x11 to sel=0, 0x22 to sel=3 with all out_ready=1 -> out_valid=0001 then 1000 on the following cycles, out_data slots 0x11 and 0x22, 1-cycle latency each.
- Backpressure: out_ready[1]=0; send 0x33 then 0x44 to sel=1 ->
  - 0x33 is held stable and in_ready=0 for the second beat;
  - raising out_ready[1] gives same-edge drain/refill, 0x44 follows with no bubble;
  - beats to sel=2 are accepted throughout.
- Streaming: 16 back-to-back beats 0x00..0x0F to sel=2 with out_ready=1 -> one beat per cycle on channel 2, in order, none lost.
- Drops: N_OUT=3; send 260 beats with sel=3 -> in_ready=1 on every beat, out_valid never set, drop_cnt reaches 255 and stays there.
- Random: a random valid/sel/ready mix for 10k cycles -> each channel's output sequence equals the scoreboard queue of accepted beats for that channel.

Source files
------------

// File: rtl/stream_demux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_demux_pkg : shared defaults and select-width helper           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package stream_demux_pkg;

   localparam int DEMUX_N_OUT = 4;
   localparam int DEMUX_W     = 8;
   localparam int DEMUX_CNT_W = 8;

   // A two-channel demux still needs one select bit, so clamp at 1.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/stream_demux_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_demux_if : input stream plus N_OUT output channels            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface stream_demux_if
   import stream_demux_pkg::*;
#(
   parameter int N_OUT = DEMUX_N_OUT,
   parameter int W     = DEMUX_W
);
   localparam int SEL_W = sel_w(N_OUT);

   logic               in_valid;
   logic               in_ready;
   logic [SEL_W-1:0]   in_sel;
   logic [W-1:0]       in_data;
   logic [N_OUT-1:0]   out_valid;
   logic [N_OUT-1:0]   out_ready;
   logic [N_OUT*W-1:0] out_data;

   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface
`default_nettype wire

// File: rtl/stream_demux_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_slot : one-entry holding register for a single output channel  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module demux_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // Load wins over drain, giving same-edge drain/refill without a bubble;
   // a plain drain leaves the data register untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (load) begin
         r_valid <= 1'b1;
         r_data  <= load_data;
      end else if (r_valid && ready) begin
         r_valid <= 1'b0;
      end
   end

   assign valid = r_valid;
   assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_demux : steers one valid/ready stream to N_OUT channels       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int N_OUT = DEMUX_N_OUT,
   parameter int W     = DEMUX_W,
   parameter int CNT_W = DEMUX_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   stream_demux_if.slave    bus,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int SEL_W = sel_w(N_OUT);
   localparam logic [SEL_W:0] c_n_out = (SEL_W+1)'(N_OUT);

   logic             w_sel_oor;
   logic             w_slot_ready;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_slot_valid [N_OUT];
   logic [W-1:0]     w_slot_data  [N_OUT];
   logic [CNT_W-1:0] r_drop_cnt;

   // Extra leading bit so N_OUT itself fits when N_OUT is a power of two.
   assign w_sel_oor = ({1'b0, bus.in_sel} >= c_n_out);

   // out_ready feeds in_ready combinationally; in_valid never does.
   always_comb begin
      w_slot_ready = 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
         if (bus.in_sel == SEL_W'(k)) begin
            w_slot_ready = !bus.out_valid[k] || bus.out_ready[k];
         end
      end
   end

   assign w_in_ready   = w_sel_oor || w_slot_ready;
   assign w_accept     = bus.in_valid && w_in_ready;
   assign bus.in_ready = w_in_ready;

   generate
      for (genvar k = 0; k < N_OUT; k++) begin : g_slot
         demux_slot #(
            .W (W)
         ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (w_accept && (bus.in_sel == SEL_W'(k))),
            .load_data (bus.in_data),
            .ready     (bus.out_ready[k]),
            .valid     (w_slot_valid[k]),
            .data      (w_slot_data[k])
         );
      end
   endgenerate

   always_comb begin
      bus.out_valid = '0;
      bus.out_data  = '0;
      for (int k = 0; k < N_OUT; k++) begin
         bus.out_valid[k]        = w_slot_valid[k];
         bus.out_data[k*W +: W]  = w_slot_data[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= '0;
      end else if (w_accept && w_sel_oor && (r_drop_cnt != {CNT_W{1'b1}})) begin
         r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
   end

   assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stream_demux : directed and randomized checks of stream_demux     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_stream_demux;
   import stream_demux_pkg::*;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] dc4;
   logic [7:0] dc3;
   int         checks = 0;
   int         errors = 0;

   stream_demux_if #(.N_OUT(4), .W(8)) if4 ();
   stream_demux_if #(.N_OUT(3), .W(8)) if3 ();

   stream_demux #(.N_OUT(4), .W(8), .CNT_W(8)) dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (if4),
      .drop_cnt (dc4)
   );

   stream_demux #(.N_OUT(3), .W(8), .CNT_W(8)) dut3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (if3),
      .drop_cnt (dc3)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] slot4(input int k);
      return if4.out_data[k*8 +: 8];
   endfunction

   task automatic test_reset();
      if4.in_valid = 1'b0; if4.in_sel = '0; if4.in_data = '0; if4.out_ready = 4'h0;
      if3.in_valid = 1'b0; if3.in_sel = '0; if3.in_data = '0; if3.out_ready = 3'h7;
      rst_n = 1'b0;
      #12;
      checks++; if (if4.out_valid !== 4'b0000) begin errors++; $display("FAIL por_valid got %b want 0000", if4.out_valid); end
      checks++; if (if4.out_data !== 32'h0) begin errors++; $display("FAIL por_data got %h want 0", if4.out_data); end
      checks++; if (dc3 !== 8'd0) begin errors++; $display("FAIL por_drop got %0d want 0", dc3); end
      @(negedge clk); rst_n = 1'b1;
      tick();
      if4.in_valid = 1'b1; if4.in_sel = 2'd2; if4.in_data = 8'hA5;
      if3.in_valid = 1'b1; if3.in_sel = 2'd3;
      tick();
      if4.in_valid = 1'b0; if3.in_valid = 1'b0;
      checks++; if (if4.out_valid !== 4'b0100) begin errors++; $display("FAIL hold_valid got %b want 0100", if4.out_valid); end
      checks++; if (slot4(2) !== 8'hA5) begin errors++; $display("FAIL hold_data got %h want a5", slot4(2)); end
      checks++; if (dc3 !== 8'd1) begin errors++; $display("FAIL pre_drop got %0d want 1", dc3); end
      #3; rst_n = 1'b0; #1;
      checks++; if (if4.out_valid !== 4'b0000) begin errors++; $display("FAIL async_valid got %b want 0000", if4.out_valid); end
      checks++; if (if4.out_data !== 32'h0) begin errors++; $display("FAIL async_data got %h want 0", if4.out_data); end
      checks++; if (dc3 !== 8'd0) begin errors++; $display("FAIL async_drop got %0d want 0", dc3); end
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      tick();
      if4.out_ready = 4'hF;
   endtask

   task automatic test_basic_steer();
      if4.out_ready = 4'hF;
      if4.in_valid = 1'b1; if4.in_sel = 2'd0; if4.in_data = 8'h11;
      @(negedge clk);
      checks++; if (if4.out_valid !== 4'b0000) begin errors++; $display("FAIL steer_latency got %b want 0000", if4.out_valid); end
      tick();
      checks++; if (if4.out_valid !== 4'b0001) begin errors++; $display("FAIL steer0_valid got %b want 0001", if4.out_valid); end
      checks++; if (slot4(0) !== 8'h11) begin errors++; $display("FAIL steer0_data got %h want 11", slot4(0)); end
      if4.in_sel = 2'd3; if4.in_data = 8'h22;
      tick();
      checks++; if (if4.out_valid !== 4'b1000) begin errors++; $display("FAIL steer3_valid got %b want 1000", if4.out_valid); end
      checks++; if (slot4(3) !== 8'h22) begin errors++; $display("FAIL steer3_data got %h want 22", slot4(3)); end
      checks++; if (slot4(0) !== 8'h11) begin errors++; $display("FAIL drain_hold got %h want 11", slot4(0)); end
      if4.in_valid = 1'b0;
      tick();
      checks++; if (if4.out_valid !== 4'b0000) begin errors++; $display("FAIL steer_idle got %b want 0000", if4.out_valid); end
   endtask

   task automatic test_backpressure();
      if4.out_ready = 4'b1101;
      if4.in_valid = 1'b1; if4.in_sel = 2'd1; if4.in_data = 8'h33;
      tick();
      checks++; if (if4.out_valid !== 4'b0010) begin errors++; $display("FAIL bp_load got %b want 0010", if4.out_valid); end
      if4.in_data = 8'h44;
      @(negedge clk);
      checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b want 0", if4.in_ready); end
      tick();
      checks++; if (slot4(1) !== 8'h33) begin errors++; $display("FAIL bp_stable got %h want 33", slot4(1)); end
      if4.in_sel = 2'd2; if4.in_data = 8'h55;
      @(negedge clk);
      checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready got %b want 1", if4.in_ready); end
      tick();
      checks++; if (if4.out_valid !== 4'b0110) begin errors++; $display("FAIL bp_other_valid got %b want 0110", if4.out_valid); end
      checks++; if (slot4(2) !== 8'h55 || slot4(1) !== 8'h33) begin errors++; $display("FAIL bp_other_data got %h/%h want 55/33", slot4(2), slot4(1)); end
      if4.in_sel = 2'd1; if4.in_data = 8'h44; if4.out_ready = 4'b1111;
      @(negedge clk);
      checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_comb_ready got %b want 1", if4.in_ready); end
      tick();
      checks++; if (if4.out_valid !== 4'b0010) begin errors++; $display("FAIL bp_refill_valid got %b want 0010", if4.out_valid); end
      checks++; if (slot4(1) !== 8'h44) begin errors++; $display("FAIL bp_refill_data got %h want 44", slot4(1)); end
      if4.in_valid = 1'b0;
      tick();
      checks++; if (if4.out_valid !== 4'b0000) begin errors++; $display("FAIL bp_idle got %b want 0000", if4.out_valid); end
   endtask

   task automatic test_back_to_back();
      if4.out_ready = 4'hF;
      for (int i = 0; i < 16; i++) begin
         if4.in_valid = 1'b1; if4.in_sel = 2'd2; if4.in_data = 8'(i);
         @(negedge clk);
         checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, if4.in_ready); end
         tick();
         checks++;
         if (if4.out_valid !== 4'b0100 || slot4(2) !== 8'(i)) begin
            errors++; $display("FAIL stream_beat[%0d] got %b/%h want 0100/%h", i, if4.out_valid, slot4(2), 8'(i));
         end
      end
      if4.in_valid = 1'b0;
      tick();
      checks++; if (if4.out_valid !== 4'b0000) begin errors++; $display("FAIL stream_idle got %b want 0000", if4.out_valid); end
   endtask

   task automatic test_drops();
      logic [7:0] exp;
      if3.out_ready = 3'b111;
      for (int i = 0; i < 260; i++) begin
         if3.in_valid = 1'b1; if3.in_sel = 2'd3; if3.in_data = 8'(i);
         @(negedge clk);
         checks++; if (if3.in_ready !== 1'b1) begin errors++; $display("FAIL drop_ready[%0d] got %b want 1", i, if3.in_ready); end
         tick();
         exp = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
         checks++; if (if3.out_valid !== 3'b000) begin errors++; $display("FAIL drop_valid[%0d] got %b want 000", i, if3.out_valid); end
         checks++; if (dc3 !== exp) begin errors++; $display("FAIL drop_cnt[%0d] got %0d want %0d", i, dc3, exp); end
      end
      if3.in_valid = 1'b0;
      checks++; if (dc4 !== 8'd0) begin errors++; $display("FAIL drop_pow2 got %0d want 0", dc4); end
   endtask

   task automatic test_random();
      logic       mv [4];
      logic [7:0] md [4];
      logic [3:0] expv;
      logic       exp_rdy;
      int         s;
      for (int k = 0; k < 4; k++) begin mv[k] = 1'b0; md[k] = 8'h0; end
      for (int c = 0; c < 10000; c++) begin
         if4.in_valid  = ($urandom_range(0, 3) != 0);
         if4.in_sel    = 2'($urandom_range(0, 3));
         if4.in_data   = 8'($urandom);
         if4.out_ready = 4'($urandom);
         @(negedge clk);
         for (int k = 0; k < 4; k++) expv[k] = mv[k];
         s = int'(if4.in_sel);
         exp_rdy = !mv[s] || if4.out_ready[s];
         checks++; if (if4.out_valid !== expv) begin errors++; $display("FAIL rnd_valid@%0d got %b want %b", c, if4.out_valid, expv); end
         checks++; if (if4.in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready@%0d got %b want %b", c, if4.in_ready, exp_rdy); end
         for (int k = 0; k < 4; k++) begin
            if (mv[k]) begin
               checks++;
               if (slot4(k) !== md[k]) begin errors++; $display("FAIL rnd_data%0d@%0d got %h want %h", k, c, slot4(k), md[k]); end
            end
         end
         for (int k = 0; k < 4; k++) if (mv[k] && if4.out_ready[k]) mv[k] = 1'b0;
         if (if4.in_valid && exp_rdy) begin mv[s] = 1'b1; md[s] = if4.in_data; end
         tick();
      end
      if4.in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_steer();
      test_backpressure();
      test_back_to_back();
      test_drops();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
